snail_pattern_fsm: RTL and testbench

Parametrised serial bit-pattern detector. Generalises the fixed five-state snail FSM into a runtime-programmable detector:
- pattern length up to W bits;
- selectable overlapping or non-overlapping matching;
- both a Mealy (combinational) and a Moore (registered) match output;
- saturating match counter.

It sits between a slow-enable strobe generator and the board LEDs/7-segment display in the lab designs.

---
 rtl/snail_pattern_fsm.sv | 120 ++++++++++++
 tb/tb_snail_pattern_fsm.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snail_pattern_fsm.sv
// snail_pattern_fsm: runtime-programmable serial bit-pattern detector.
//
// A shift register keeps the most recent accepted bits. Each enabled
// bit is checked against the low len bits of the programmed pattern,
// with the new bit taken as the last bit of the sequence.
//
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   en           bit-sample enable; a is consumed only when en=1
//   a            serial input bit
//   load         capture cfg_pattern/cfg_len/cfg_ovl and clear history
//   cfg_pattern  new pattern (bit 0 = last bit, bit len-1 = first bit)
//   cfg_len      new pattern length
//   cfg_ovl      new overlap mode (1 = overlapping matches allowed)
//   cnt_clr      synchronous clear of match_cnt (wins over increment)
//   y            Mealy match, combinational, same cycle as the final bit
//   y_moore      registered copy of y, one cycle later
//   match_cnt    saturating match counter
//   cfg_valid    1 when 1 <= active length <= W
module snail_pattern_fsm #(
    parameter int unsigned  W        = 8,
    parameter int unsigned  LEN_W    = $clog2(W + 1),
    parameter int unsigned  CNT_W    = 8,
    parameter logic [W-1:0] PAT_INIT = W'(8'b0001_0110),
    parameter int unsigned  LEN_INIT = 5,
    parameter bit           OVL_INIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             a,
    input  logic             load,
    input  logic [W-1:0]     cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_ovl,
    input  logic             cnt_clr,
    output logic             y,
    output logic             y_moore,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cfg_valid
);

    localparam logic [LEN_W:0]   W_EXT    = (LEN_W + 1)'(W);
    localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(W);

    // Active configuration
    logic [W-1:0]     pat;
    logic [LEN_W-1:0] len;
    logic             ovl;

    // Bit history (hist[0] = newest) and number of bits accepted since clear
    logic [W-1:0]     hist;
    logic [LEN_W-1:0] fill;

    logic [W-1:0]     cand;
    logic [W-1:0]     mask;
    logic [LEN_W:0]   fill_inc;
    logic             len_reached;
    logic             pat_hit;
    logic             fill_full;

    // Candidate window, compare mask and Mealy match
    always_comb begin
        cand = {hist[W-2:0], a};
        mask = '0;
        for (int i = 0; i < int'(W); i++) begin
            mask[i] = (LEN_W'(i) < len);
        end
        cfg_valid   = (len != '0) && ({1'b0, len} <= W_EXT);
        fill_inc    = {1'b0, fill} + (LEN_W + 1)'(1);
        len_reached = (fill_inc >= {1'b0, len});
        pat_hit     = (((cand ^ pat) & mask) == '0);
        fill_full   = (fill == FILL_MAX);
        y           = en & cfg_valid & ~load & len_reached & pat_hit;
    end

    // Configuration, history, fill counter and Moore output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat     <= PAT_INIT;
            len     <= LEN_W'(LEN_INIT);
            ovl     <= OVL_INIT;
            hist    <= '0;
            fill    <= '0;
            y_moore <= 1'b0;
        end else if (load) begin
            // The bit presented alongside load is dropped on purpose
            pat     <= cfg_pattern;
            len     <= cfg_len;
            ovl     <= cfg_ovl;
            hist    <= '0;
            fill    <= '0;
            y_moore <= 1'b0;
        end else begin
            y_moore <= y;
            if (en) begin
                hist <= cand;
                // Non-overlapping mode restarts the count so the next match
                // needs len fresh bits; history keeps shifting regardless
                if (y && !ovl) begin
                    fill <= '0;
                end else if (!fill_full) begin
                    fill <= fill + LEN_W'(1);
                end
            end
        end
    end

    // Saturating match counter; clear overrides a same-cycle match
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_cnt <= '0;
        end else if (cnt_clr) begin
            match_cnt <= '0;
        end else if (y && (match_cnt != '1)) begin
            match_cnt <= match_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_snail_pattern_fsm.sv
// Testbench for snail_pattern_fsm: directed vector table, hand-written
// corner sequences and random stimulus against a behavioural model.
module tb_snail_pattern_fsm;

    localparam int W     = 8;
    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             en, a, load, cfg_ovl, cnt_clr;
    logic [W-1:0]     cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             y, y_moore, cfg_valid;
    logic [7:0]       match_cnt;
    logic             y2, y_moore2, cfg_valid2;
    logic [1:0]       cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    snail_pattern_fsm #(.W(W), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .a(a), .load(load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl),
        .cnt_clr(cnt_clr), .y(y), .y_moore(y_moore),
        .match_cnt(match_cnt), .cfg_valid(cfg_valid)
    );

    snail_pattern_fsm #(.W(W), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .a(a), .load(load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl),
        .cnt_clr(cnt_clr), .y(y2), .y_moore(y_moore2),
        .match_cnt(cnt2), .cfg_valid(cfg_valid2)
    );

    // ---------------- behavioural model ----------------
    int m_pat, m_len, m_ovl, m_fill, m_cnt, m_cnt2, m_moore, m_y;
    int m_hist[W];   // m_hist[k] = bit received k+1 accepted bits ago

    function automatic void model_reset();
        m_pat = 'h16; m_len = 5; m_ovl = 0;
        m_fill = 0; m_cnt = 0; m_cnt2 = 0; m_moore = 0; m_y = 0;
        for (int k = 0; k < W; k++) m_hist[k] = 0;
    endfunction

    function automatic int model_valid();
        return (m_len >= 1 && m_len <= W) ? 1 : 0;
    endfunction

    function automatic int model_match(input int e, input int av, input int ld);
        int b;
        if (e == 0 || ld != 0 || model_valid() == 0) return 0;
        if (m_fill + 1 < m_len) return 0;
        for (int k = 0; k < m_len; k++) begin
            b = (k == 0) ? av : m_hist[k-1];
            if (b != ((m_pat >> k) & 1)) return 0;
        end
        return 1;
    endfunction

    function automatic void model_commit();
        if (cnt_clr) begin
            m_cnt = 0; m_cnt2 = 0;
        end else if (m_y != 0) begin
            if (m_cnt < 255) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
        if (load) begin
            m_pat = int'(cfg_pattern); m_len = int'(cfg_len); m_ovl = int'(cfg_ovl);
            for (int k = 0; k < W; k++) m_hist[k] = 0;
            m_fill = 0; m_moore = 0;
        end else begin
            m_moore = m_y;
            if (en) begin
                for (int k = W - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
                m_hist[0] = int'(a);
                if (m_y != 0 && m_ovl == 0) m_fill = 0;
                else if (m_fill < W) m_fill++;
            end
        end
    endfunction

    // ---------------- check / drive helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit e, input bit av, input bit ld, input logic [7:0] p,
                         input logic [3:0] l, input bit o, input bit c);
        @(negedge clk);
        en = e; a = av; load = ld; cfg_pattern = p; cfg_len = l; cfg_ovl = o; cnt_clr = c;
        #1;
        m_y = model_match(int'(e), int'(av), int'(ld));
        chk("y", 32'(y), 32'(m_y));
        chk("y_moore", 32'(y_moore), 32'(m_moore));
        chk("match_cnt", 32'(match_cnt), 32'(m_cnt));
        chk("match_cnt_sat", 32'(cnt2), 32'(m_cnt2));
        chk("cfg_valid", 32'(cfg_valid), 32'(model_valid()));
    endtask

    task automatic commit();
        @(posedge clk);
        model_commit();
    endtask

    task automatic cycle(input bit e, input bit av, input bit ld, input logic [7:0] p,
                         input logic [3:0] l, input bit o, input bit c);
        drive(e, av, ld, p, l, o, c);
        commit();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit         en;
        bit         a;
        bit         load;
        logic [7:0] pat;
        logic [3:0] len;
        bit         ovl;
        bit         clr;
        bit         ey;
        bit         em;
        int         ec;
    } vec_t;

    function automatic vec_t mk(input bit e, input bit av, input bit ld, input logic [7:0] p,
                                input logic [3:0] l, input bit o, input bit c,
                                input bit ey, input bit em, input int ec);
        vec_t v;
        v.en = e; v.a = av; v.load = ld; v.pat = p; v.len = l; v.ovl = o; v.clr = c;
        v.ey = ey; v.em = em; v.ec = ec;
        return v;
    endfunction

    initial begin
        vec_t  tbl[$];
        bit    rb;
        bit    ld;
        logic [3:0] rl;
        logic [7:0] bits;

        // default pattern 10110, len 5, non-overlap
        tbl.push_back(mk(1,1,0,8'h00,0,0,0, 0,0,0));
        tbl.push_back(mk(1,0,0,8'h00,0,0,0, 0,0,0));
        tbl.push_back(mk(1,1,0,8'h00,0,0,0, 0,0,0));
        tbl.push_back(mk(1,1,0,8'h00,0,0,0, 0,0,0));
        tbl.push_back(mk(1,0,0,8'h00,0,0,0, 1,0,0));
        tbl.push_back(mk(0,0,0,8'h00,0,0,0, 0,1,1));
        // pattern 101 overlapping: matches on bits 3 and 5
        tbl.push_back(mk(0,0,1,8'h05,3,1,1, 0,0,1));
        tbl.push_back(mk(1,1,0,8'h00,0,0,0, 0,0,0));
        tbl.push_back(mk(1,0,0,8'h00,0,0,0, 0,0,0));
        tbl.push_back(mk(1,1,0,8'h00,0,0,0, 1,0,0));
        tbl.push_back(mk(1,0,0,8'h00,0,0,0, 0,1,1));
        tbl.push_back(mk(1,1,0,8'h00,0,0,0, 1,0,1));
        tbl.push_back(mk(0,0,0,8'h00,0,0,0, 0,1,2));
        // pattern 101 non-overlapping: only bit 3 matches
        tbl.push_back(mk(0,0,1,8'h05,3,0,1, 0,0,2));
        tbl.push_back(mk(1,1,0,8'h00,0,0,0, 0,0,0));
        tbl.push_back(mk(1,0,0,8'h00,0,0,0, 0,0,0));
        tbl.push_back(mk(1,1,0,8'h00,0,0,0, 1,0,0));
        tbl.push_back(mk(1,0,0,8'h00,0,0,0, 0,1,1));
        tbl.push_back(mk(1,1,0,8'h00,0,0,0, 0,0,1));
        tbl.push_back(mk(0,0,0,8'h00,0,0,0, 0,0,1));
        // load collides with a would-be final bit of pattern 001
        tbl.push_back(mk(0,0,1,8'h01,3,0,1, 0,0,1));
        tbl.push_back(mk(1,0,0,8'h00,0,0,0, 0,0,0));
        tbl.push_back(mk(1,0,0,8'h00,0,0,0, 0,0,0));
        tbl.push_back(mk(1,1,1,8'h01,3,0,0, 0,0,0));
        tbl.push_back(mk(1,1,0,8'h00,0,0,0, 0,0,0));
        tbl.push_back(mk(1,0,0,8'h00,0,0,0, 0,0,0));
        tbl.push_back(mk(1,0,0,8'h00,0,0,0, 0,0,0));
        tbl.push_back(mk(1,1,0,8'h00,0,0,0, 1,0,0));
        tbl.push_back(mk(0,0,0,8'h00,0,0,0, 0,1,1));
        // enable gating with default pattern, a toggling on en=0 cycles
        tbl.push_back(mk(0,0,1,8'h16,5,0,1, 0,0,1));
        tbl.push_back(mk(1,1,0,8'h00,0,0,0, 0,0,0));
        tbl.push_back(mk(0,0,0,8'h00,0,0,0, 0,0,0));
        tbl.push_back(mk(1,0,0,8'h00,0,0,0, 0,0,0));
        tbl.push_back(mk(0,1,0,8'h00,0,0,0, 0,0,0));
        tbl.push_back(mk(1,1,0,8'h00,0,0,0, 0,0,0));
        tbl.push_back(mk(0,0,0,8'h00,0,0,0, 0,0,0));
        tbl.push_back(mk(1,1,0,8'h00,0,0,0, 0,0,0));
        tbl.push_back(mk(0,1,0,8'h00,0,0,0, 0,0,0));
        tbl.push_back(mk(1,0,0,8'h00,0,0,0, 1,0,0));
        tbl.push_back(mk(0,1,0,8'h00,0,0,0, 0,1,1));
        tbl.push_back(mk(0,0,0,8'h00,0,0,0, 0,0,1));

        // reset state
        model_reset();
        rst = 1'b1; en = 0; a = 0; load = 0; cfg_pattern = '0; cfg_len = '0;
        cfg_ovl = 0; cnt_clr = 0;
        #12;
        chk("rst_y", 32'(y), 32'd0);
        chk("rst_y_moore", 32'(y_moore), 32'd0);
        chk("rst_match_cnt", 32'(match_cnt), 32'd0);
        chk("rst_cfg_valid", 32'(cfg_valid), 32'd1);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].en, tbl[i].a, tbl[i].load, tbl[i].pat, tbl[i].len, tbl[i].ovl, tbl[i].clr);
            chk($sformatf("vec%0d_y", i), 32'(y), 32'(tbl[i].ey));
            chk($sformatf("vec%0d_y_moore", i), 32'(y_moore), 32'(tbl[i].em));
            chk($sformatf("vec%0d_cnt", i), 32'(match_cnt), 32'(tbl[i].ec));
            commit();
        end

        // invalid length 0: no matches over random bits
        cycle(0, 0, 1, 8'h00, 4'd0, 0, 0);
        drive(0, 0, 0, 8'h00, 4'd0, 0, 0);
        chk("len0_cfg_valid", 32'(cfg_valid), 32'd0);
        commit();
        for (int i = 0; i < 20; i++) begin
            drive(1, 1'($urandom % 2), 0, 8'h00, 4'd0, 0, 0);
            chk("len0_y", 32'(y), 32'd0);
            commit();
        end
        // length above W is also invalid
        cycle(0, 0, 1, 8'hFF, 4'd9, 1, 0);
        drive(1, 1, 0, 8'h00, 4'd0, 0, 0);
        chk("len9_cfg_valid", 32'(cfg_valid), 32'd0);
        chk("len9_y", 32'(y), 32'd0);
        commit();

        // length 1, pattern 1: every a=1 bit matches
        cycle(0, 0, 1, 8'h01, 4'd1, 0, 0);
        for (int i = 0; i < 12; i++) begin
            rb = 1'($urandom % 2);
            drive(1, rb, 0, 8'h00, 4'd0, 0, 0);
            chk("len1_y", 32'(y), 32'(rb));
            commit();
        end

        // full length W, pattern 0xA5
        cycle(0, 0, 1, 8'hA5, 4'd8, 0, 0);
        bits = 8'hA5;
        for (int i = 7; i >= 0; i--) begin
            drive(1, bits[i], 0, 8'h00, 4'd0, 0, 0);
            chk("lenW_y", 32'(y), (i == 0) ? 32'd1 : 32'd0);
            commit();
        end

        // counter saturation: 5 matches
        cycle(0, 0, 1, 8'h01, 4'd1, 0, 1);
        for (int i = 0; i < 5; i++) cycle(1, 1, 0, 8'h00, 4'd0, 0, 0);
        drive(0, 0, 0, 8'h00, 4'd0, 0, 0);
        chk("sat_cnt2", 32'(cnt2), 32'd3);
        chk("sat_cnt8", 32'(match_cnt), 32'd5);
        commit();
        // clear wins over a simultaneous match
        drive(1, 1, 0, 8'h00, 4'd0, 0, 1);
        chk("clr_match_y", 32'(y), 32'd1);
        commit();
        drive(0, 0, 0, 8'h00, 4'd0, 0, 0);
        chk("clr_cnt", 32'(match_cnt), 32'd0);
        chk("clr_cnt2", 32'(cnt2), 32'd0);
        commit();

        // mid-sequence asynchronous reset
        cycle(1, 1, 0, 8'h00, 4'd0, 0, 0);
        cycle(1, 1, 0, 8'h00, 4'd0, 0, 0);
        @(negedge clk);
        en = 0; a = 0;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_y_moore", 32'(y_moore), 32'd0);
        chk("midrst_cnt", 32'(match_cnt), 32'd0);
        chk("midrst_y", 32'(y), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        bits = 8'h16;
        for (int i = 4; i >= 0; i--) begin
            drive(1, bits[i], 0, 8'h00, 4'd0, 0, 0);
            chk("midrst_default_y", 32'(y), (i == 0) ? 32'd1 : 32'd0);
            commit();
        end

        // random stimulus against the model
        for (int i = 0; i < 600; i++) begin
            ld = (($urandom % 16) == 0);
            rl = (($urandom % 4) == 0) ? 4'($urandom_range(0, 10)) : 4'($urandom_range(1, 3));
            cycle(1'(($urandom % 4) != 0), 1'($urandom % 2), ld, 8'($urandom), rl,
                  1'($urandom % 2), 1'(($urandom % 32) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
